// File: rtl/blackparrot_fpga_host_nbf_sipo.sv
// -----------------------------------------------------------------------------
// blackparrot_fpga_host_nbf_sipo
//
// Serial-in / parallel-out assembler for NBF (network boot format) packets.
// A packet arrives as a stream of 32-bit words: one opcode word, then
// A = nbf_addr_width_p/32 address words, then D = nbf_data_width_p/32 data
// words. Address and data words arrive least-significant word first. Once
// the packet is fully collected, it is presented on the pkt_* outputs with a
// valid/ready handshake.
//
// Optional feature (compile-time macro):
//   BP_FPGA_HOST_NBF_SIPO_OPCODE_CHECK_EN
//     defined   : a packet whose opcode is not supported is consumed in full,
//                 then dropped. opcode_err_o is set and stays set until reset.
//     undefined : every opcode is forwarded. opcode_err_o is tied to 0.
//
// Ports:
//   s_axil_aclk      in   clock; all state changes on its rising edge
//   s_axil_aresetn   in   asynchronous active-low reset
//   nbf_v_i          in   input word valid
//   nbf_data_i       in   serialized NBF word (fifo_data_width_p bits)
//   nbf_ready_and_o  out  input word accepted when high together with nbf_v_i
//   pkt_v_o          out  assembled packet valid
//   pkt_opcode_o     out  packet opcode
//   pkt_addr_o       out  packet address
//   pkt_data_o       out  packet data
//   pkt_ready_and_i  in   downstream accepts the packet when high with pkt_v_o
//   pkt_count_o      out  number of packets handed downstream (wraps)
//   opcode_err_o     out  sticky unsupported-opcode flag
// -----------------------------------------------------------------------------
module blackparrot_fpga_host_nbf_sipo #(
  parameter int fifo_data_width_p  = 32,
  parameter int nbf_opcode_width_p = 8,
  parameter int nbf_addr_width_p   = 64,
  parameter int nbf_data_width_p   = 64
) (
  input  logic                          s_axil_aclk,
  input  logic                          s_axil_aresetn,
  input  logic                          nbf_v_i,
  input  logic [fifo_data_width_p-1:0]  nbf_data_i,
  output logic                          nbf_ready_and_o,
  output logic                          pkt_v_o,
  output logic [nbf_opcode_width_p-1:0] pkt_opcode_o,
  output logic [nbf_addr_width_p-1:0]   pkt_addr_o,
  output logic [nbf_data_width_p-1:0]   pkt_data_o,
  input  logic                          pkt_ready_and_i,
  output logic [31:0]                   pkt_count_o,
  output logic                          opcode_err_o
);

  localparam int a_words = nbf_addr_width_p / 32;
  localparam int d_words = nbf_data_width_p / 32;

  // The word counter only needs to reach the last index of a 2-word field.
  localparam logic [1:0] a_last = 2'(a_words - 1);
  localparam logic [1:0] d_last = 2'(d_words - 1);

  typedef logic [nbf_opcode_width_p-1:0] opcode_t;

  typedef enum logic [1:0] {
    e_opcode,
    e_addr,
    e_data,
    e_send
  } state_e;

  state_e                        state_r, state_n;
  logic [1:0]                    cnt_r, cnt_n;
  logic                          ready_r;
  opcode_t                       pkt_opcode_r;
  logic [nbf_addr_width_p-1:0]   pkt_addr_r;
  logic [nbf_data_width_p-1:0]   pkt_data_r;
  logic [31:0]                   pkt_count_r;

  logic in_hs;
  logic out_hs;
  logic last_data_hs;
  logic opcode_ok;

  assign in_hs        = nbf_v_i & ready_r;
  assign out_hs       = (state_r == e_send) & pkt_ready_and_i;
  assign last_data_hs = in_hs & (state_r == e_data) & (cnt_r == d_last);

`ifdef BP_FPGA_HOST_NBF_SIPO_OPCODE_CHECK_EN
  function automatic logic opcode_supported(input opcode_t op);
    return op inside {opcode_t'(8'h00), opcode_t'(8'h01), opcode_t'(8'h02),
                      opcode_t'(8'h03), opcode_t'(8'h10), opcode_t'(8'h11),
                      opcode_t'(8'h12), opcode_t'(8'h13), opcode_t'(8'hFE),
                      opcode_t'(8'hFF)};
  endfunction

  assign opcode_ok = opcode_supported(pkt_opcode_r);
`else
  assign opcode_ok = 1'b1;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_opcode: if (in_hs) state_n = e_addr;
      e_addr:   if (in_hs && cnt_r == a_last) state_n = e_data;
      // An unsupported packet has been fully consumed at this point, so the
      // stream stays aligned when it is dropped straight back to e_opcode.
      e_data:   if (last_data_hs) state_n = opcode_ok ? e_send : e_opcode;
      e_send:   if (out_hs) state_n = e_opcode;
      default:  state_n = e_opcode;
    endcase

    cnt_n = cnt_r;
    if (state_n != state_r) begin
      cnt_n = 2'd0;
    end else if (in_hs && (state_r == e_addr || state_r == e_data)) begin
      cnt_n = cnt_r + 2'd1;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      state_r <= e_opcode;
      cnt_r   <= 2'd0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      // Ready is registered so it stays low during reset and rises on the
      // first edge after release; it tracks "next state is not e_send".
      ready_r <= (state_n != e_send);
    end
  end

  // NOTE: the packet registers are visible outputs, so they are reset to a
  // known value rather than left as free-running datapath storage.
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      pkt_opcode_r <= '0;
      pkt_addr_r   <= '0;
      pkt_data_r   <= '0;
    end else if (in_hs) begin
      unique case (state_r)
        e_opcode: pkt_opcode_r <= nbf_data_i[nbf_opcode_width_p-1:0];
        e_addr: begin
          for (int k = 0; k < a_words; k++) begin
            if (cnt_r == 2'(k)) pkt_addr_r[k*32 +: 32] <= nbf_data_i[31:0];
          end
        end
        e_data: begin
          for (int k = 0; k < d_words; k++) begin
            if (cnt_r == 2'(k)) pkt_data_r[k*32 +: 32] <= nbf_data_i[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      pkt_count_r <= 32'd0;
    end else if (out_hs) begin
      pkt_count_r <= pkt_count_r + 32'd1;
    end
  end

`ifdef BP_FPGA_HOST_NBF_SIPO_OPCODE_CHECK_EN
  logic opcode_err_r;

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      opcode_err_r <= 1'b0;
    end else if (last_data_hs && !opcode_ok) begin
      opcode_err_r <= 1'b1;
    end
  end

  assign opcode_err_o = opcode_err_r;
`else
  assign opcode_err_o = 1'b0;
`endif

  assign nbf_ready_and_o = ready_r;
  assign pkt_v_o         = (state_r == e_send);
  assign pkt_opcode_o    = pkt_opcode_r;
  assign pkt_addr_o      = pkt_addr_r;
  assign pkt_data_o      = pkt_data_r;
  assign pkt_count_o     = pkt_count_r;

endmodule

// File: tb/tb_blackparrot_fpga_host_nbf_sipo.sv
module tb_blackparrot_fpga_host_nbf_sipo;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
  } pkt_t;

  logic clk;
  logic rst_n;

  // 64/64 instance
  logic        v64, rdy64, pv64, prdy64, err64;
  logic [31:0] d64, cnt64;
  logic [7:0]  op64;
  logic [63:0] addr64, data64;

  // 32/32 instance
  logic        v32, rdy32, pv32, prdy32, err32;
  logic [31:0] d32, cnt32;
  logic [7:0]  op32;
  logic [31:0] addr32, data32;

  int errors = 0;
  int checks = 0;

  pkt_t        q64[$];
  pkt_t        q32[$];
  logic [31:0] exp_cnt64 = 32'd0;
  logic [31:0] exp_cnt32 = 32'd0;

  blackparrot_fpga_host_nbf_sipo dut64 (
    .s_axil_aclk     (clk),
    .s_axil_aresetn  (rst_n),
    .nbf_v_i         (v64),
    .nbf_data_i      (d64),
    .nbf_ready_and_o (rdy64),
    .pkt_v_o         (pv64),
    .pkt_opcode_o    (op64),
    .pkt_addr_o      (addr64),
    .pkt_data_o      (data64),
    .pkt_ready_and_i (prdy64),
    .pkt_count_o     (cnt64),
    .opcode_err_o    (err64)
  );

  blackparrot_fpga_host_nbf_sipo #(
    .nbf_addr_width_p (32),
    .nbf_data_width_p (32)
  ) dut32 (
    .s_axil_aclk     (clk),
    .s_axil_aresetn  (rst_n),
    .nbf_v_i         (v32),
    .nbf_data_i      (d32),
    .nbf_ready_and_o (rdy32),
    .pkt_v_o         (pv32),
    .pkt_opcode_o    (op32),
    .pkt_addr_o      (addr32),
    .pkt_data_o      (data32),
    .pkt_ready_and_i (prdy32),
    .pkt_count_o     (cnt32),
    .opcode_err_o    (err32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed=timeout expected=handshake", tag);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the word is taken.
  task automatic send_word(input bit sel, input logic [31:0] w);
    bit got;
    got = 1'b0;
    if (sel) begin v32 = 1'b1; d32 = w; end
    else     begin v64 = 1'b1; d64 = w; end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = sel ? rdy32 : rdy64;
      @(posedge clk);
      #1;
    end
    v32 = 1'b0;
    v64 = 1'b0;
    if (!got) fail_now("word_accept");
  endtask

  task automatic send_pkt64(input logic [7:0] op, input logic [63:0] addr,
                            input logic [63:0] data, input bit emit, input int gap);
    pkt_t p;
    p.op = op; p.addr = addr; p.data = data;
    if (emit) q64.push_back(p);
    send_word(1'b0, {24'd0, op}); idle(gap);
    send_word(1'b0, addr[31:0]);  idle(gap);
    send_word(1'b0, addr[63:32]); idle(gap);
    send_word(1'b0, data[31:0]);  idle(gap);
    send_word(1'b0, data[63:32]);
  endtask

  // Scoreboard: a packet pending handshake at this negedge is consumed at the
  // next rising edge.
  always @(negedge clk) begin
    pkt_t e;
    if (rst_n && pv64 && prdy64) begin
      if (q64.size() == 0) begin
        fail_now("unexpected_pkt64");
      end else begin
        e = q64.pop_front();
        check("pkt64_op",   {56'd0, op64}, {56'd0, e.op});
        check("pkt64_addr", addr64, e.addr);
        check("pkt64_data", data64, e.data);
        exp_cnt64 = exp_cnt64 + 32'd1;
      end
    end
    if (rst_n && pv32 && prdy32) begin
      if (q32.size() == 0) begin
        fail_now("unexpected_pkt32");
      end else begin
        e = q32.pop_front();
        check("pkt32_op",   {56'd0, op32}, {56'd0, e.op});
        check("pkt32_addr", {32'd0, addr32}, e.addr);
        check("pkt32_data", {32'd0, data32}, e.data);
        exp_cnt32 = exp_cnt32 + 32'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt_t p;
    rst_n = 1'b0;
    v64 = 1'b0; d64 = '0; prdy64 = 1'b0;
    v32 = 1'b0; d32 = '0; prdy32 = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready",  {63'd0, rdy64}, 64'd0);
    check("rst_pkt_v",  {63'd0, pv64},  64'd0);
    check("rst_count",  {32'd0, cnt64}, 64'd0);
    check("rst_err",    {63'd0, err64}, 64'd0);
    check("rst_opcode", {56'd0, op64},  64'd0);
    check("rst_addr",   addr64, 64'd0);
    check("rst_data",   data64, 64'd0);
    check("rst_ready32", {63'd0, rdy32}, 64'd0);

    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", {63'd0, rdy64}, 64'd1);
    @(posedge clk); #1;

    // Basic packet with downstream always ready
    prdy64 = 1'b1;
    send_pkt64(8'h03, 64'h0000_0000_8000_0000, 64'h1234_5678_DEAD_BEEF, 1'b1, 0);
    @(negedge clk);
    check("pv_after_last",    {63'd0, pv64},  64'd1);
    check("ready_low_in_send", {63'd0, rdy64}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_out_hs", {63'd0, rdy64}, 64'd1);
    check("pv_cleared",         {63'd0, pv64},  64'd0);
    check("count_after_1",      {32'd0, cnt64}, 64'd1);
    @(posedge clk); #1;

    // Downstream back-pressure for 10 cycles, with input stalls between words
    prdy64 = 1'b0;
    send_pkt64(8'h10, 64'h0000_0001_0000_0040, 64'hCAFE_F00D_0123_4567, 1'b1, 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_pv",     {63'd0, pv64},  64'd1);
      check("hold_ready",  {63'd0, rdy64}, 64'd0);
      check("hold_opcode", {56'd0, op64},  64'h10);
      check("hold_addr",   addr64, 64'h0000_0001_0000_0040);
      check("hold_data",   data64, 64'hCAFE_F00D_0123_4567);
      @(posedge clk); #1;
    end
    prdy64 = 1'b1;
    idle(1);
    @(negedge clk);
    check("ready_after_release_bp", {63'd0, rdy64}, 64'd1);
    check("count_after_2",           {32'd0, cnt64}, 64'd2);
    @(posedge clk); #1;

    // Reset mid-packet discards the partial packet
    send_word(1'b0, 32'h0000_0002);
    send_word(1'b0, 32'h1111_1111);
    send_word(1'b0, 32'h2222_2222);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pv",    {63'd0, pv64},  64'd0);
    check("midrst_ready", {63'd0, rdy64}, 64'd0);
    check("midrst_count", {32'd0, cnt64}, 64'd0);
    q64.delete();
    exp_cnt64 = 32'd0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt64(8'hFF, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_00AA, 1'b1, 0);
    idle(3);
    @(negedge clk);
    check("after_rst_count", {32'd0, cnt64}, 64'd1);
    check("after_rst_model", {32'd0, cnt64}, {32'd0, exp_cnt64});
    @(posedge clk); #1;

    // Unsupported opcode followed by a valid packet
`ifdef BP_FPGA_HOST_NBF_SIPO_OPCODE_CHECK_EN
    send_pkt64(8'h55, 64'h0000_0000_5555_0000, 64'h0000_0000_0000_5555, 1'b0, 0);
`else
    send_pkt64(8'h55, 64'h0000_0000_5555_0000, 64'h0000_0000_0000_5555, 1'b1, 0);
`endif
    send_pkt64(8'h02, 64'h0000_0000_0000_2000, 64'h0000_0000_0000_0002, 1'b1, 0);
    idle(3);
    @(negedge clk);
`ifdef BP_FPGA_HOST_NBF_SIPO_OPCODE_CHECK_EN
    check("opc_err",   {63'd0, err64}, 64'd1);
    check("opc_count", {32'd0, cnt64}, 64'd2);
`else
    check("opc_err",   {63'd0, err64}, 64'd0);
    check("opc_count", {32'd0, cnt64}, 64'd3);
`endif
    @(posedge clk); #1;

    // 32-bit address/data configuration: three words per packet
    prdy32 = 1'b1;
    p.op = 8'h01; p.addr = 64'h1000; p.data = 64'hAB;
    q32.push_back(p);
    send_word(1'b1, 32'h0000_0001);
    send_word(1'b1, 32'h0000_1000);
    send_word(1'b1, 32'h0000_00AB);
    @(negedge clk);
    check("w32_pv",    {63'd0, pv32},  64'd1);
    check("w32_ready", {63'd0, rdy32}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("w32_count", {32'd0, cnt32}, 64'd1);
    check("w32_err",   {63'd0, err32}, 64'd0);
    @(posedge clk); #1;

    // Counter wrap from 0xFFFFFFFF
    force dut64.pkt_count_r = 32'hFFFF_FFFF;
    #1;
    release dut64.pkt_count_r;
    exp_cnt64 = 32'hFFFF_FFFF;
    @(negedge clk);
    check("preload_count", {32'd0, cnt64}, 64'h0000_0000_FFFF_FFFF);
    @(posedge clk); #1;
    send_pkt64(8'h00, 64'h0000_0000_0000_0008, 64'h0000_0000_0000_0009, 1'b1, 0);
    idle(3);
    @(negedge clk);
    check("wrap_count",   {32'd0, cnt64}, 64'd0);
    check("wrap_model",   {32'd0, cnt64}, {32'd0, exp_cnt64});
    check("q64_drained",  64'(q64.size()), 64'd0);
    check("q32_drained",  64'(q32.size()), 64'd0);
    check("count32_model", {32'd0, cnt32}, {32'd0, exp_cnt32});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blackparrot_fpga_host_nbf_sipo.md
BLACKPARROT_FPGA_HOST_NBF_SIPO -- requirements
Module: blackparrot_fpga_host_nbf_sipo

Interface
REQ-001 SHALL provide parameter fifo_data_width_p, default 32, meaning the input word width; only 32 is legal.
REQ-002 SHALL provide parameter nbf_opcode_width_p, default 8, meaning the opcode field width.
REQ-003 SHALL provide parameter nbf_addr_width_p, default 64, meaning the address field width; legal values 32 or 64.
REQ-004 SHALL provide parameter nbf_data_width_p, default 64, meaning the data field width; legal values 32 or 64.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 s_axil_aclk  input  1  sole clock; all state updates on its rising edge.
REQ-007 s_axil_aresetn  input  1  asynchronous, active-low reset.
REQ-008 nbf_v_i  input  1  input word valid.
REQ-009 nbf_data_i  input  fifo_data_width_p  serialized NBF word.
REQ-010 nbf_ready_and_o  output  1  input word accepted when high together with nbf_v_i.
REQ-011 pkt_v_o  output  1  assembled packet valid.
REQ-012 pkt_opcode_o  output  nbf_opcode_width_p  packet opcode.
REQ-013 pkt_addr_o  output  nbf_addr_width_p  packet address.
REQ-014 pkt_data_o  output  nbf_data_width_p  packet data.
REQ-015 pkt_ready_and_i  input  1  downstream accepts the packet when high together with pkt_v_o.
REQ-016 pkt_count_o  output  32  count of packets handed downstream.
REQ-017 opcode_err_o  output  1  sticky flag for an unsupported opcode.

Function
REQ-018 The packet SHALL be 1 opcode word, then A = nbf_addr_width_p/32 address words, then D = nbf_data_width_p/32 data words.
REQ-019 The opcode SHALL be taken from the opcode word's bits [nbf_opcode_width_p-1:0]; the remaining bits SHALL be ignored.
REQ-020 Address and data words SHALL arrive least-significant first: word k fills bits [32k+31:32k].
REQ-021 The FSM SHALL have four states:
- e_opcode -> e_addr on an input handshake.
- e_addr -> e_data after A input handshakes.
- e_data -> e_send after D input handshakes.
- e_send -> e_opcode on an output handshake.
REQ-022 A word counter SHALL track the position within the address or data field; it SHALL clear on each state change.
REQ-023 nbf_ready_and_o SHALL be 1 in e_opcode, e_addr and e_data, and 0 in e_send.
REQ-024 pkt_v_o SHALL be 1 only in e_send; it SHALL assert the cycle after the final data word is accepted.
REQ-025 pkt_opcode_o, pkt_addr_o and pkt_data_o SHALL be registered and held stable while pkt_v_o=1 and pkt_ready_and_i=0.
REQ-026 After an output handshake, nbf_ready_and_o SHALL be 1 on the next cycle; peak throughput is one packet per 1+A+D+1 cycles.
REQ-027 nbf_v_i=0 in any collecting state SHALL hold all state; stalls of any length are legal.
REQ-028 pkt_ready_and_i asserted outside e_send SHALL have no effect.
REQ-029 pkt_count_o SHALL increment by 1 per output handshake and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-030 While s_axil_aresetn=0, the block SHALL be in e_opcode with the word counter and pkt_count_o at 0, opcode_err_o=0, pkt_v_o=0, nbf_ready_and_o=0, and the packet registers at 0.
REQ-031 Reset asserted mid-packet or in e_send SHALL discard the partial or pending packet; no packet is emitted for it.
REQ-032 nbf_ready_and_o SHALL be 1 on the first clock edge after reset is released.

Configuration
REQ-033 Macro BP_FPGA_HOST_NBF_SIPO_OPCODE_CHECK_EN SHALL control opcode checking as follows.
REQ-034 Defined:
- Supported opcodes are 0x00-0x03, 0x10-0x13, 0xFE and 0xFF.
- A packet with any other opcode SHALL still have all 1+A+D words consumed, to keep framing aligned.
- After its final word the FSM SHALL go directly to e_opcode; no pkt_v_o, no count increment.
- opcode_err_o SHALL set to 1 and stay 1 until reset.
REQ-035 Undefined: every opcode SHALL be forwarded and opcode_err_o SHALL be tied to 0.

Verification
REQ-036 A=D=2; words 0x03, 0x80000000, 0x0, 0xDEADBEEF, 0x12345678, pkt_ready_and_i=1 -> next cycle pkt_v_o=1, opcode 0x03, addr 0x0000000080000000, data 0x12345678DEADBEEF; pkt_count_o becomes 1.
REQ-037 Same packet with pkt_ready_and_i=0 for 10 cycles -> outputs stable and nbf_ready_and_o=0 throughout; on release, handshake completes and count becomes 1.
REQ-038 Reset asserted after 3 of 5 words, then a full packet with opcode 0xFF -> exactly one packet emitted, opcode 0xFF, count 1.
REQ-039 Macro defined; packet with opcode 0x55 followed by a valid 0x02 packet -> first packet dropped, opcode_err_o=1, second packet emitted, count 1. Macro undefined -> both packets emitted, opcode_err_o=0.
REQ-040 nbf_addr_width_p=32, nbf_data_width_p=32; words 0x01, 0x1000, 0xAB -> packet opcode 0x01, addr 0x1000, data 0xAB, 3 words consumed.
REQ-041 Count preloaded via 2^32-1 packets or a forced value 0xFFFFFFFF, then one more packet -> pkt_count_o=0.
